// File: rtl/traffic_lamp_monitor.sv
// Lamp driver and health monitor: registers controller light commands into lamp drives,
// generates flash phases, checks lamp-current feedback, and latches failures.
module traffic_lamp_monitor #(
  parameter int FLASH_HALF   = 4,
  parameter int MISMATCH_LIM = 3,
  parameter int CW           = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       GreenA,
  input  logic       YellowA,
  input  logic       RedA,
  input  logic       FlashingYellowA,
  input  logic       GreenB,
  input  logic       YellowB,
  input  logic       RedB,
  input  logic       FlashingYellowB,
  input  logic       RedCrossing,
  input  logic       GreenCrossing,
  input  logic       FlashingGreenCrossing,
  input  logic [7:0] LampSense,
  input  logic       ClearFault,
  output logic [7:0] LampDrive,
  output logic       FailureDetect,
  output logic [1:0] FailCode,
  output logic [2:0] FailLamp,
  output logic       fsm_state
);

  typedef enum logic { RUN = 1'b0, FAULT = 1'b1 } state_t;

  localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_HALF - 1);
  localparam logic [CW-1:0] MC_TRIP    = CW'(MISMATCH_LIM - 1);
  localparam logic [CW-1:0] MC_MAX     = '1;

  state_t        state;
  logic [CW-1:0] flash_cnt;
  logic          phase;
  logic [CW-1:0] mc [8];

  logic          flash_any;
  logic          conflict;
  logic          cnt_wrap;
  logic [CW-1:0] cnt_adv;
  logic          phase_adv;
  logic [7:0]    run_drive;
  logic [7:0]    fault_drive;
  logic [7:0]    mismatch;
  logic [7:0]    changed;
  logic [7:0]    lamp_fault;
  logic [2:0]    first_lamp;

  always_comb begin
    flash_any = FlashingYellowA | FlashingYellowB | FlashingGreenCrossing;

    conflict = (GreenA & (GreenB | GreenCrossing | FlashingGreenCrossing))
             | (RedCrossing & (GreenCrossing | FlashingGreenCrossing))
             | (GreenA & RedA)
             | (GreenB & RedB)
             | ~(GreenA | YellowA | RedA | FlashingYellowA);

    cnt_wrap  = (flash_cnt == FLASH_LAST);
    cnt_adv   = cnt_wrap ? '0 : flash_cnt + 1'b1;
    phase_adv = cnt_wrap ? ~phase : phase;

    run_drive = {GreenCrossing | (FlashingGreenCrossing & phase),
                 RedCrossing,
                 RedB,
                 YellowB | (FlashingYellowB & phase),
                 GreenB,
                 RedA,
                 YellowA | (FlashingYellowA & phase),
                 GreenA};
    fault_drive = {3'b000, phase, 2'b00, phase, 1'b0};

    // A drive change this edge gives the lamp one cycle to respond, so it never counts.
    mismatch   = LampSense ^ LampDrive;
    changed    = run_drive ^ LampDrive;
    lamp_fault = '0;
    first_lamp = '0;
    for (int i = 7; i >= 0; i--) begin
      lamp_fault[i] = mismatch[i] & ~changed[i] & (mc[i] >= MC_TRIP);
      if (lamp_fault[i]) first_lamp = 3'(i);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= RUN;
      LampDrive     <= '0;
      FailureDetect <= 1'b0;
      FailCode      <= 2'd0;
      FailLamp      <= 3'd0;
      flash_cnt     <= '0;
      phase         <= 1'b1;
      for (int i = 0; i < 8; i++) mc[i] <= '0;
    end else begin
      case (state)
        RUN: begin
          if (conflict || (|lamp_fault)) begin
            state         <= FAULT;
            FailureDetect <= 1'b1;
            FailCode      <= conflict ? 2'd1 : 2'd2;
            FailLamp      <= conflict ? 3'd0 : first_lamp;
            LampDrive     <= fault_drive;
            flash_cnt     <= cnt_adv;
            phase         <= phase_adv;
            for (int i = 0; i < 8; i++) mc[i] <= '0;
          end else begin
            LampDrive <= run_drive;
            // Idle flash generator parks "on" so a new flash starts lit.
            if (flash_any) begin
              flash_cnt <= cnt_adv;
              phase     <= phase_adv;
            end else begin
              flash_cnt <= '0;
              phase     <= 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
              if (!mismatch[i] || changed[i]) mc[i] <= '0;
              else if (mc[i] != MC_MAX)       mc[i] <= mc[i] + 1'b1;
            end
          end
        end
        FAULT: begin
          for (int i = 0; i < 8; i++) mc[i] <= '0;
          if (ClearFault && !conflict) begin
            state         <= RUN;
            FailureDetect <= 1'b0;
            FailCode      <= 2'd0;
            FailLamp      <= 3'd0;
            LampDrive     <= run_drive;
            flash_cnt     <= '0;
            phase         <= 1'b1;
          end else begin
            LampDrive <= fault_drive;
            flash_cnt <= cnt_adv;
            phase     <= phase_adv;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign fsm_state = (state == FAULT);

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor: steady drive, flashing, lamp fault,
// command conflict, fault clearing and asynchronous reset out of FAULT.
module tb_traffic_lamp_monitor;

  localparam logic [10:0] GA  = 11'h001;
  localparam logic [10:0] RA  = 11'h004;
  localparam logic [10:0] FYA = 11'h008;
  localparam logic [10:0] GB  = 11'h010;
  localparam logic [10:0] RB  = 11'h040;
  localparam logic [10:0] FYB = 11'h080;
  localparam logic [10:0] RC  = 11'h100;

  logic        Clk;
  logic        Rst;
  logic [10:0] cmd;
  logic [7:0]  LampSense;
  logic        ClearFault;
  logic [7:0]  LampDrive;
  logic        FailureDetect;
  logic [1:0]  FailCode;
  logic [2:0]  FailLamp;
  logic        fsm_state;

  logic [7:0]  stuck0;
  logic [7:0]  stuck1;
  int          checks;
  int          errors;

  traffic_lamp_monitor #(.FLASH_HALF(4), .MISMATCH_LIM(3), .CW(4)) dut (
    .Clk                   (Clk),
    .Rst                   (Rst),
    .GreenA                (cmd[0]),
    .YellowA               (cmd[1]),
    .RedA                  (cmd[2]),
    .FlashingYellowA       (cmd[3]),
    .GreenB                (cmd[4]),
    .YellowB               (cmd[5]),
    .RedB                  (cmd[6]),
    .FlashingYellowB       (cmd[7]),
    .RedCrossing           (cmd[8]),
    .GreenCrossing         (cmd[9]),
    .FlashingGreenCrossing (cmd[10]),
    .LampSense             (LampSense),
    .ClearFault            (ClearFault),
    .LampDrive             (LampDrive),
    .FailureDetect         (FailureDetect),
    .FailCode              (FailCode),
    .FailLamp              (FailLamp),
    .fsm_state             (fsm_state)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Lamps follow the drive one cycle late, with optional stuck bits.
  task automatic tick();
    logic [7:0] d_before;
    d_before = LampDrive;
    @(posedge Clk);
    #1;
    LampSense = (d_before & ~stuck0) | stuck1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] flash_exp [9];

  initial begin
    checks     = 0;
    errors     = 0;
    Rst        = 1'b1;
    cmd        = '0;
    LampSense  = '0;
    ClearFault = 1'b0;
    stuck0     = '0;
    stuck1     = '0;
    flash_exp  = '{8'h52, 8'h52, 8'h52, 8'h52, 8'h40, 8'h40, 8'h40, 8'h40, 8'h52};

    tick();
    tick();
    check("rst_drive", 32'(LampDrive), 32'h00);
    check("rst_fd", 32'(FailureDetect), 32'd0);
    check("rst_code", 32'(FailCode), 32'd0);
    check("rst_lamp", 32'(FailLamp), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);

    // Steady legal aspect
    cmd = GA | RB | RC;
    Rst = 1'b0;
    tick();
    check("steady_drive", 32'(LampDrive), 32'h61);
    for (int i = 0; i < 50; i++) tick();
    check("steady_fd", 32'(FailureDetect), 32'd0);
    check("steady_drive_50", 32'(LampDrive), 32'h61);

    // Flashing yellows: 4 on / 4 off starting on
    cmd = FYA | FYB | RC;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("flash_%0d", i), 32'(LampDrive), 32'(flash_exp[i]));
    end
    check("flash_fd", 32'(FailureDetect), 32'd0);

    // Lamp 0 never lights
    cmd    = GA;
    stuck0 = 8'h01;
    tick();
    check("lamp_drive_ga", 32'(LampDrive), 32'h01);
    tick();
    tick();
    check("lamp_fd_early", 32'(FailureDetect), 32'd0);
    tick();
    check("lamp_fd", 32'(FailureDetect), 32'd1);
    check("lamp_code", 32'(FailCode), 32'd2);
    check("lamp_idx", 32'(FailLamp), 32'd0);
    check("lamp_state", 32'(fsm_state), 32'd1);
    check("fault_drive_on", 32'(LampDrive), 32'h12);
    tick();
    tick();
    tick();
    check("fault_drive_on_last", 32'(LampDrive), 32'h12);
    tick();
    check("fault_drive_off", 32'(LampDrive), 32'h00);

    // Clear with legal commands
    cmd        = GA | RB | RC;
    stuck0     = '0;
    ClearFault = 1'b1;
    tick();
    ClearFault = 1'b0;
    check("clear1_fd", 32'(FailureDetect), 32'd0);
    check("clear1_code", 32'(FailCode), 32'd0);
    check("clear1_drive", 32'(LampDrive), 32'h61);
    tick();
    tick();

    // One-cycle green/green conflict with a sense glitch on lamp 3
    cmd    = GA | GB | RC;
    stuck1 = 8'h08;
    tick();
    cmd = GA | RB | RC;
    check("conf_fd", 32'(FailureDetect), 32'd1);
    check("conf_code", 32'(FailCode), 32'd1);
    check("conf_lamp", 32'(FailLamp), 32'd0);
    check("conf_drive", 32'(LampDrive), 32'h12);
    tick();
    tick();
    check("conf_code_frozen", 32'(FailCode), 32'd1);

    // Clear refused while a conflict is present
    cmd        = GA | RA;
    ClearFault = 1'b1;
    tick();
    check("clear_blocked_fd", 32'(FailureDetect), 32'd1);
    check("clear_blocked_code", 32'(FailCode), 32'd1);
    cmd    = GA | RB | RC;
    stuck1 = '0;
    tick();
    ClearFault = 1'b0;
    check("clear2_fd", 32'(FailureDetect), 32'd0);
    check("clear2_code", 32'(FailCode), 32'd0);
    check("clear2_lamp", 32'(FailLamp), 32'd0);
    check("clear2_drive", 32'(LampDrive), 32'h61);

    // ClearFault in RUN has no effect
    ClearFault = 1'b1;
    tick();
    ClearFault = 1'b0;
    check("clear_run_fd", 32'(FailureDetect), 32'd0);
    check("clear_run_drive", 32'(LampDrive), 32'h61);

    // Reset two cycles into FAULT
    cmd = GA | GB | RC;
    tick();
    cmd = GA | RB | RC;
    check("pre_rst_fd", 32'(FailureDetect), 32'd1);
    tick();
    tick();
    Rst = 1'b1;
    #1;
    check("async_rst_fd", 32'(FailureDetect), 32'd0);
    check("async_rst_drive", 32'(LampDrive), 32'h00);
    check("async_rst_code", 32'(FailCode), 32'd0);
    check("async_rst_state", 32'(fsm_state), 32'd0);
    #1;
    Rst = 1'b0;
    #1;
    check("post_rst_drive", 32'(LampDrive), 32'h00);
    tick();
    check("resume_drive", 32'(LampDrive), 32'h61);
    check("resume_fd", 32'(FailureDetect), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_monitor.md
# traffic_lamp_monitor

Lamp driver and health monitor at the output end of the traffic-light controller. Registers the controller's eleven light commands into eight physical lamp drives, generates flashing phases, and compares each drive against its lamp-current sense input. Flags illegal command combinations and persistent lamp mismatches as a latched `FailureDetect`, which is fed back to the controller's failure input.

## Interface
- `FLASH_HALF`, 4: clock cycles per flash half-period (on or off); ≥2.
- `MISMATCH_LIM`, 3: consecutive mismatched samples that declare a lamp fault; 1..`FLASH_HALF`.
- `CW`, 4: width of flash and mismatch counters; 2^`CW` > max(`FLASH_HALF`, `MISMATCH_LIM`).
- `Clk` in 1: clock; all state updates on the rising edge.
- `Rst` in 1: reset, asynchronous, active-high.
- Road A commands, in 1 each: `GreenA`, `YellowA`, `RedA`, `FlashingYellowA`.
- Road B commands, in 1 each: `GreenB`, `YellowB`, `RedB`, `FlashingYellowB`.
- Crossing commands, in 1 each: `RedCrossing`, `GreenCrossing`, `FlashingGreenCrossing`.
- `LampSense` in 8: lamp current present, per lamp, same bit order as `LampDrive`.
- `ClearFault` in 1: synchronous single-cycle request to leave FAULT.
- `LampDrive` out 8: bit order 0 GreenA, 1 YellowA, 2 RedA, 3 GreenB, 4 YellowB, 5 RedB, 6 RedCrossing, 7 GreenCrossing.
- `FailureDetect` out 1: high while in FAULT.
- `FailCode` out 2: 0 none, 1 command conflict, 2 lamp mismatch.
- `FailLamp` out 3: index of the faulty lamp when `FailCode`=2, else 0.

## Operation
- FSM states are RUN and FAULT; reset enters RUN.
- Flash generator:
  - `FlashCnt` counts 0..`FLASH_HALF`-1 and toggles `Phase` on wrap.
  - When no flash command is active and the state is RUN, it holds `FlashCnt`=0 and `Phase`=1, so the first flash cycle is always "on".
- Drive mapping in RUN (registered):
  - Each steady command drives its lamp.
  - `FlashingYellowA` drives bit 1 = `Phase`, ORed with `YellowA`.
  - `FlashingYellowB` drives bit 4 = `Phase`, ORed with `YellowB`.
  - `FlashingGreenCrossing` drives bit 7 = `Phase`, ORed with `GreenCrossing`.
- Drive in FAULT: bits 1 and 4 = `Phase`; all other bits 0, regardless of commands. The flash generator runs continuously in FAULT.
- Conflicts, each checked every cycle in RUN:
  - `GreenA` & (`GreenB` | `GreenCrossing` | `FlashingGreenCrossing`).
  - `RedCrossing` & (`GreenCrossing` | `FlashingGreenCrossing`).
  - `GreenA` & `RedA`.
  - `GreenB` & `RedB`.
  - No road-A command active at all (`GreenA`, `YellowA`, `RedA`, `FlashingYellowA` all 0).
- Mismatch, per lamp i, with saturating counter `Mc[i]`:
  - `Mc[i]` clears when `LampSense[i]` == `LampDrive[i]` or when `LampDrive[i]` changed on this edge; otherwise it increments.
  - A lamp fault is declared when `Mc[i]` reaches `MISMATCH_LIM`.
- RUN→FAULT on a conflict or a lamp fault.
  - Latch `FailCode`.
  - Conflict has priority over mismatch on the same edge.
  - Among simultaneous lamp faults, the lowest index wins for `FailLamp`.
- In FAULT:
  - `FailCode`/`FailLamp` are frozen; later faults do not overwrite them.
  - All `Mc` counters are held at 0.
- FAULT→RUN on `ClearFault`=1 and no conflict present that cycle.
  - Clears `FailCode`, `FailLamp`, all `Mc`, and the flash generator.
  - `ClearFault` in RUN is ignored.

## Timing
- Reset values: state RUN, `LampDrive`=0, `FailureDetect`=0, `FailCode`=0, `FailLamp`=0, all `Mc`=0, `FlashCnt`=0, `Phase`=1.
- Command to `LampDrive`: 1 cycle of latency.
- Sense is compared against the current registered `LampDrive`. The lamp is allowed 1 edge of response: a change in drive clears `Mc`.
- Conflict sampled at edge k → `FailureDetect`=1 and `FailCode`=1 after edge k. In the same edge, `LampDrive` switches to the FAULT pattern.
- Mismatch present at edges k..k+`MISMATCH_LIM`-1 → `FailureDetect`=1 after edge k+`MISMATCH_LIM`-1.
- `ClearFault` accepted at edge k → `FailureDetect`=0 after edge k. The RUN drive pattern appears after edge k.
- Flash waveform: period 2·`FLASH_HALF` cycles, 50% duty, starting "on" on the first edge after the flash command (or FAULT) is registered.
- A broken flashing lamp is detected within one "on" half-period, because `MISMATCH_LIM` ≤ `FLASH_HALF`.
- `Rst` mid-FAULT: immediately returns to RUN with the reset values above and `LampDrive`=0 until the next edge.

## Test plan
- Reset, then `GreenA`=`RedB`=`RedCrossing`=1 with `LampSense` tracking `LampDrive` one cycle late → `LampDrive`=8'b0110_0001 after 1 edge; `FailureDetect` stays 0 for 50 cycles.
- `FlashingYellowA`=`FlashingYellowB`=1 with sense tracking → bits 1 and 4 show a 4-on/4-off waveform starting "on"; no fault.
- Steady `GreenA` with `LampSense[0]` forced 0 → `FailureDetect`=1, `FailCode`=2, `FailLamp`=0 after the 3rd mismatched edge. `LampDrive` then flashes bits 1 and 4 only.
- `GreenA`=`GreenB`=1 for one cycle → `FailureDetect`=1, `FailCode`=1 after that edge. A simultaneous `LampSense[3]` mismatch does not change `FailCode`.
- In FAULT, `ClearFault` pulsed while a conflict is still present → stays in FAULT. Pulsed again with legal commands → `FailureDetect`=0 after 1 edge; codes clear.
- `Rst` asserted 2 cycles into FAULT → outputs immediately 0 and state RUN; normal drive resumes 1 edge after deassertion.
